// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The subtractor is the slave; the producer/consumer side is the master.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             borrowin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport slave (
    input  in_valid, in1, in2, borrowin, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );

  modport master (
    output in_valid, in1, in2, borrowin, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell plus a borrow flop,
// producing in1 - in2 - borrowin after WIDTH RUN cycles.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             br_q, br_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic d_bit;
  logic bo_bit;

  // Full-subtractor cell on the current LSBs and the running borrow.
  always_comb begin
    d_bit  = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    bo_bit = (~a_sh_q[0] & b_sh_q[0]) | (~a_sh_q[0] & br_q) | (b_sh_q[0] & br_q);
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    br_d     = br_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d   = bus.in1;
          b_sh_d   = bus.in2;
          br_d     = bus.borrowin;
          sign_a_d = bus.in1[WIDTH-1];
          sign_b_d = bus.in2[WIDTH-1];
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Shift-then-overwrite the MSB works for every WIDTH, including 1.
        res_sh_d            = res_sh_q >> 1;
        res_sh_d[WIDTH-1]   = d_bit;
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        br_d                = bo_bit;
        cnt_d               = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      br_q     <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      br_q     <= br_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = res_sh_q;
  assign bus.borrow    = br_q;
  assign bus.ovf       = (sign_a_q != sign_b_q) & (res_sh_q[WIDTH-1] != sign_a_q);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for arithmetic,
// backpressure and mid-run reset, and a 1-bit instance for the cell truth table.
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_subtractor_if #(.WIDTH(8)) s8 ();
  serial_subtractor_if #(.WIDTH(1)) s1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(s8));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(s1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic bin, input logic [7:0] exp_d, input logic exp_b,
                      input logic exp_o);
    int lat;
    s8.in1      = a;
    s8.in2      = b;
    s8.borrowin = bin;
    s8.in_valid = 1'b1;
    cycle();
    s8.in_valid = 1'b0;
    check({tag, "_busy"}, s8.in_ready, 0);
    lat = 0;
    while (!s8.out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check({tag, "_lat"}, lat, 8);
    check({tag, "_diff"}, s8.diff, exp_d);
    check({tag, "_borrow"}, s8.borrow, exp_b);
    check({tag, "_ovf"}, s8.ovf, exp_o);
    s8.out_ready = 1'b1;
    cycle();
    s8.out_ready = 1'b0;
    check({tag, "_ovld_drop"}, s8.out_valid, 0);
    check({tag, "_rdy_back"}, s8.in_ready, 1);
  endtask

  task automatic run1(input int idx, input logic a, input logic b, input logic bin,
                      input logic exp_d, input logic exp_b, input logic exp_o);
    int lat;
    s1.in1      = a;
    s1.in2      = b;
    s1.borrowin = bin;
    s1.in_valid = 1'b1;
    cycle();
    s1.in_valid = 1'b0;
    lat = 0;
    while (!s1.out_valid && lat < 10) begin
      cycle();
      lat++;
    end
    check($sformatf("w1_%0d_lat", idx), lat, 1);
    check($sformatf("w1_%0d_diff", idx), s1.diff, exp_d);
    check($sformatf("w1_%0d_borrow", idx), s1.borrow, exp_b);
    check($sformatf("w1_%0d_ovf", idx), s1.ovf, exp_o);
    s1.out_ready = 1'b1;
    cycle();
    s1.out_ready = 1'b0;
  endtask

  // {a, b, bin, d, bo, ovf} for the 1-bit build.
  logic [5:0] tt [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tt = '{6'b000_000, 6'b001_110, 6'b010_111, 6'b011_010,
           6'b100_100, 6'b101_001, 6'b110_000, 6'b111_110};

    rst = 1'b1;
    s8.in_valid = 1'b0; s8.out_ready = 1'b0; s8.in1 = '0; s8.in2 = '0; s8.borrowin = 1'b0;
    s1.in_valid = 1'b0; s1.out_ready = 1'b0; s1.in1 = '0; s1.in2 = '0; s1.borrowin = 1'b0;
    cycle();
    rst = 1'b0;
    check("rst_in_ready", s8.in_ready, 1);
    check("rst_out_valid", s8.out_valid, 0);
    check("rst_diff", s8.diff, 0);
    check("rst_borrow", s8.borrow, 0);
    check("rst_ovf", s8.ovf, 0);

    run8("t50_20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    run8("t00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run8("t05_05b", 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0);
    run8("t80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run8("t7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Backpressure: result held for 5 cycles while new operands are offered.
    s8.in1 = 8'h33; s8.in2 = 8'h11; s8.borrowin = 1'b0; s8.in_valid = 1'b1;
    cycle();
    s8.in_valid = 1'b0;
    for (int k = 0; k < 20 && !s8.out_valid; k++) cycle();
    for (int k = 0; k < 5; k++) begin
      s8.in1 = 8'hAA; s8.in2 = 8'h01; s8.borrowin = 1'b1;
      s8.in_valid = (k == 1 || k == 2);
      check($sformatf("bp%0d_ovld", k), s8.out_valid, 1);
      check($sformatf("bp%0d_irdy", k), s8.in_ready, 0);
      check($sformatf("bp%0d_diff", k), s8.diff, 8'h22);
      check($sformatf("bp%0d_borrow", k), s8.borrow, 0);
      check($sformatf("bp%0d_ovf", k), s8.ovf, 0);
      cycle();
    end
    s8.in_valid  = 1'b0;
    s8.out_ready = 1'b1;
    cycle();
    s8.out_ready = 1'b0;
    check("bp_rdy_back", s8.in_ready, 1);
    check("bp_ovld_drop", s8.out_valid, 0);
    cycle();
    check("bp_not_consumed", s8.in_ready, 1);

    // Reset in the 3rd RUN cycle of 0x50 - 0x20.
    s8.in1 = 8'h50; s8.in2 = 8'h20; s8.borrowin = 1'b0; s8.in_valid = 1'b1;
    cycle();
    s8.in_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_in_ready", s8.in_ready, 1);
    check("abort_out_valid", s8.out_valid, 0);
    check("abort_diff", s8.diff, 0);
    check("abort_borrow", s8.borrow, 0);
    run8("t10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [5:0] v;
      v = tt[i];
      run1(i, v[5], v[4], v[3], v[2], v[1], v[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first N-bit subtractor built around a single full-subtractor cell and a borrow flip-flop. It computes in1 − in2 − borrowin over WIDTH clock cycles and trades latency for area, as the complement to the team's ripple full-adder datapath. It sits between an upstream operand producer and a downstream result consumer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 1
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands on in1/in2/borrowin are valid
- in_ready  out  1  block can accept operands
- in1  in  WIDTH  minuend, unsigned or two's complement
- in2  in  WIDTH  subtrahend
- borrowin  in  1  borrow-in, subtracted at bit 0
- out_valid  out  1  diff/borrow/ovf hold a valid result
- out_ready  in  1  consumer accepts the result
- diff  out  WIDTH  (in1 − in2 − borrowin) mod 2^WIDTH
- borrow  out  1  1 iff in1 < in2 + borrowin (unsigned)
- ovf  out  1  two's-complement overflow of the subtraction

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. If in_valid = 1 on a clock edge, latch in1 → a_sh, in2 → b_sh, borrowin → br, store the sign bits of in1 and in2, clear cnt, and move to RUN.
- RUN: each cycle, the cell computes d = a0 ^ b0 ^ br and bo = (~a0 & b0) | (~a0 & br) | (b0 & br), where a0 and b0 are the LSBs of a_sh and b_sh.
  - d is shifted into the MSB of res_sh (right shift), and a_sh and b_sh shift right.
  - br ← bo and cnt ← cnt + 1.
  - When cnt = WIDTH−1 (the last bit), move to DONE.
- DONE: out_valid = 1.
  - diff = res_sh, borrow = br.
  - ovf = (sign_a ≠ sign_b) & (diff[WIDTH−1] ≠ sign_a).
  - If out_ready = 1 on an edge, move to IDLE.
  - Outputs hold stable while out_ready = 0.
- in_ready = 0 in RUN and DONE. in_valid is ignored in those states, and no operand is queued.
- Only the cell's outputs (bo, d) are combinational. All outputs are registered or decoded from state.
- cnt is $clog2(WIDTH+1) bits wide and never wraps during an operation.
- WIDTH = 1: RUN lasts exactly one cycle.

## Timing
- Reset (rst = 1 at an edge) sets state = IDLE, cnt = 0, br = 0, res_sh = 0, and the sign regs to 0.
  - The following cycle shows in_ready = 1, out_valid = 0, diff = 0, borrow = 0, ovf = 0.
- Reset during RUN or DONE aborts the operation. No out_valid is produced for it, and any partial result is discarded.
- Reset has priority over every handshake at the same edge.
- Latency: operands are accepted at edge E; out_valid is first high in the cycle after edge E+WIDTH.
- Minimum issue interval is WIDTH+2 cycles: WIDTH RUN cycles, 1 DONE cycle, and 1 IDLE cycle.
- An input handshake and an output handshake never occur in the same cycle.
- diff, borrow, and ovf are undefined-free outside DONE. They hold their last shifted values and must not be sampled without out_valid.

## Test plan
- WIDTH=8, in1=0x50, in2=0x20, borrowin=0 → diff=0x30, borrow=0, ovf=0. out_valid rises exactly 8 edges after the accept edge.
- in1=0x00, in2=0x01, borrowin=0 → diff=0xFF, borrow=1, ovf=0. Then in1=0x05, in2=0x05, borrowin=1 → diff=0xFF, borrow=1.
- in1=0x80, in2=0x01 → diff=0x7F, borrow=0, ovf=1. in1=0x7F, in2=0xFF → diff=0x80, borrow=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands.
  - diff, borrow, ovf, and out_valid stay constant, and in_ready stays 0.
  - The pulsed operands are not consumed.
  - After out_ready=1, in_ready=1 on the next cycle.
- Assert rst for one cycle at the 3rd RUN cycle of 0x50−0x20.
  - Next cycle: in_ready=1, out_valid=0, diff=0.
  - A subsequent 0x10−0x01 yields diff=0x0F, borrow=0.
- WIDTH=1 build: all 8 combinations of in1, in2, borrowin match the full-subtractor truth table. out_valid rises 1 edge after accept.
